// File: rtl/bcd_div_pkg.sv
// Shared types and helpers for the streaming BCD divisibility checker.
// The optional divisible-by-7 output is enabled with BCD_DIV_CHECK_DIV7_EN.
package bcd_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } stateT;

    localparam int MOD3  = 3;
    localparam int MOD11 = 11;
    localparam int MOD7  = 7;

    // Weight of the previous remainder per new digit: 10 mod 3 = 1, 10 mod 11 = 10 (i.e. -1), 10 mod 7 = 3
    localparam int MULT3  = 1;
    localparam int MULT11 = 10;
    localparam int MULT7  = 3;

    function automatic logic bcd_is_valid(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_mod_accum.sv
// Running remainder of a decimal number modulo MOD, folding in one digit per enable.
// remNext exposes the post-fold value so the caller can register a verdict on the same edge.
module bcd_mod_accum #(
    parameter int MOD  = 3,
    parameter int MULT = 1,
    localparam int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [3:0]   digit,
    output logic [W-1:0] rem,
    output logic [W-1:0] remNext
);

    // Worst case is MULT=10, rem=10, digit=15 -> 115, which fits in 8 bits
    logic [7:0] sum;

    assign sum     = 8'(MULT) * 8'(rem) + 8'(digit);
    assign remNext = W'(sum % 8'(MOD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
        end else if (clr) begin
            rem <= '0;
        end else if (en) begin
            rem <= remNext;
        end
    end

endmodule

// File: rtl/bcd_div_checker_stream.sv
// Streaming BCD divisibility checker: one digit per cycle, MSD first, reports div3/div11.
// Define BCD_DIV_CHECK_DIV7_EN to add a div7 output that also feeds result.
module bcd_div_checker_stream
    import bcd_div_pkg::*;
#(
    parameter int  MAX_DIGITS = 4,
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic [3:0]       digit,
    input  logic             digit_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             div3,
    output logic             div11,
    output logic             result,
    output logic             bad_digit,
    output logic [CNT_W-1:0] digit_count
`ifdef BCD_DIV_CHECK_DIV7_EN
    ,
    output logic             div7
`endif
);

    stateT            stateReg, stateNext;
    logic [CNT_W-1:0] countReg, countNext, countInc;
    logic             badReg, badNext, badNow;
    logic             accept, lastHit, clrRem;

    logic             digitReadyNext, resValidNext;
    logic             div3Next, div11Next, resultNext, badDigitNext;
    logic [CNT_W-1:0] digitCountNext;
    logic             isDiv3, isDiv11, isAny;

    logic [1:0]       rem3, rem3Next;
    logic [3:0]       rem11, rem11Next;

    assign accept   = digit_valid & digit_ready;
    assign countInc = countReg + 1'b1;
    assign lastHit  = digit_last | (countInc == CNT_W'(MAX_DIGITS));
    assign badNow   = badReg | ~bcd_is_valid(digit);
    assign isDiv3   = (rem3Next == 2'd0) & ~badNow;
    assign isDiv11  = (rem11Next == 4'd0) & ~badNow;

    bcd_mod_accum #(.MOD(MOD3), .MULT(MULT3)) u_rem3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clrRem),
        .en      (accept),
        .digit   (digit),
        .rem     (rem3),
        .remNext (rem3Next)
    );

    bcd_mod_accum #(.MOD(MOD11), .MULT(MULT11)) u_rem11 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clrRem),
        .en      (accept),
        .digit   (digit),
        .rem     (rem11),
        .remNext (rem11Next)
    );

`ifdef BCD_DIV_CHECK_DIV7_EN
    logic [2:0] rem7, rem7Next;
    logic       isDiv7, div7Next;

    bcd_mod_accum #(.MOD(MOD7), .MULT(MULT7)) u_rem7 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clrRem),
        .en      (accept),
        .digit   (digit),
        .rem     (rem7),
        .remNext (rem7Next)
    );

    assign isDiv7 = (rem7Next == 3'd0) & ~badNow;
    assign isAny  = isDiv3 | isDiv11 | isDiv7;
`else
    assign isAny  = isDiv3 | isDiv11;
`endif

    always_comb begin
        stateNext      = stateReg;
        countNext      = countReg;
        badNext        = badReg;
        clrRem         = 1'b0;
        digitReadyNext = digit_ready;
        resValidNext   = res_valid;
        div3Next       = div3;
        div11Next      = div11;
        resultNext     = result;
        badDigitNext   = bad_digit;
        digitCountNext = digit_count;
`ifdef BCD_DIV_CHECK_DIV7_EN
        div7Next       = div7;
`endif

        case (stateReg)
            IDLE, ACCUM: begin
                if (accept) begin
                    countNext = countInc;
                    badNext   = badNow;
                    if (lastHit) begin
                        // Verdict is taken from the post-fold remainders so it lands on this edge
                        stateNext      = DONE;
                        digitReadyNext = 1'b0;
                        resValidNext   = 1'b1;
                        div3Next       = isDiv3;
                        div11Next      = isDiv11;
                        resultNext     = isAny;
                        badDigitNext   = badNow;
                        digitCountNext = countInc;
`ifdef BCD_DIV_CHECK_DIV7_EN
                        div7Next       = isDiv7;
`endif
                    end else begin
                        stateNext = ACCUM;
                    end
                end
            end
            DONE: begin
                if (res_valid & res_ready) begin
                    stateNext      = IDLE;
                    resValidNext   = 1'b0;
                    digitReadyNext = 1'b1;
                    countNext      = '0;
                    badNext        = 1'b0;
                    clrRem         = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            countReg    <= '0;
            badReg      <= 1'b0;
            digit_ready <= 1'b1;
            res_valid   <= 1'b0;
            div3        <= 1'b0;
            div11       <= 1'b0;
            result      <= 1'b0;
            bad_digit   <= 1'b0;
            digit_count <= '0;
        end else begin
            stateReg    <= stateNext;
            countReg    <= countNext;
            badReg      <= badNext;
            digit_ready <= digitReadyNext;
            res_valid   <= resValidNext;
            div3        <= div3Next;
            div11       <= div11Next;
            result      <= resultNext;
            bad_digit   <= badDigitNext;
            digit_count <= digitCountNext;
        end
    end

`ifdef BCD_DIV_CHECK_DIV7_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div7 <= 1'b0;
        end else begin
            div7 <= div7Next;
        end
    end
`endif

endmodule
